// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the frame scheduler, its clients and the UART
// transmitter. The scheduler takes the slave view; the client/UART side
// takes the master view.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   byte_ack;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 trmt;
  logic [7:0]           tx_data;
  logic                 tx_done;

  modport master (
    output req, req_data, req_last, tx_done,
    input  byte_ack, gnt, busy, trmt, tx_data
  );

  modport slave (
    input  req, req_data, req_last, tx_done,
    output byte_ack, gnt, busy, trmt, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler in front of a single 8N1 UART transmitter.
// One client owns the UART for a whole frame; bytes are streamed one at a
// time (trmt/tx_done handshake), then an optional idle gap is forced before
// the next arbitration.
// Build option: define UART_SCHED_HDR_EN to prefix every frame with a header
// byte {4'hA, client_id}. Without it no header logic exists.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_GAP} state_t;
  state_t r_state, w_state_nxt;

  logic [IW-1:0]            r_rr_ptr;
  logic [IW-1:0]            r_gidx;
  logic [NUM_REQ-1:0]       r_gnt;
  logic [NUM_REQ-1:0]       r_byte_ack;
  logic                     r_trmt;
  logic [7:0]               r_tx_data;
  logic                     r_last_q;
  logic [GW-1:0]            r_gap_cnt;
`ifdef UART_SCHED_HDR_EN
  logic                     r_hdr_pend;
  logic [3:0]               w_hdr_id;
  assign w_hdr_id = 4'(r_gidx);
`endif

  logic [IW-1:0]            w_win_idx;
  logic                     w_win_vld;
  logic                     w_wait_done;
  logic                     w_gap_end;
  logic                     w_frame_cont;
  logic [NUM_REQ-1:0][7:0]  w_lane_byte;
  logic [7:0]               w_cur_byte;

  // Split the flat client data bus into one byte per lane
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign w_lane_byte[i] = bus.req_data[8*i +: 8];
  end

  assign w_cur_byte = w_lane_byte[r_gidx];

  // The trmt cycle still shows the previous byte's done level, so skip it
  assign w_wait_done  = (r_state == ST_WAIT) && !r_trmt && bus.tx_done;
  assign w_frame_cont = !r_last_q && bus.req[r_gidx];
  assign w_gap_end    = (r_gap_cnt == GW'(GAP_CYC - 1));

  // Round-robin search: first pending client strictly above rr_ptr, wrapping
  always_comb begin
    int idx;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_win_vld && bus.req[IW'(idx)]) begin
        w_win_vld = 1'b1;
        w_win_idx = IW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_win_vld) w_state_nxt = ST_SEND;
      ST_SEND: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_wait_done) begin
          if (w_frame_cont)      w_state_nxt = ST_SEND;
          else if (GAP_CYC == 0) w_state_nxt = ST_IDLE;
          else                   w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  if (w_gap_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant, byte launch and gap counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= IW'(NUM_REQ - 1);
      r_gidx     <= '0;
      r_gnt      <= '0;
      r_byte_ack <= '0;
      r_trmt     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_last_q   <= 1'b0;
      r_gap_cnt  <= '0;
`ifdef UART_SCHED_HDR_EN
      r_hdr_pend <= 1'b0;
`endif
    end else begin
      r_trmt     <= 1'b0;
      r_byte_ack <= '0;
      r_gap_cnt  <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_gidx     <= w_win_idx;
            r_rr_ptr   <= w_win_idx;
            r_gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
`ifdef UART_SCHED_HDR_EN
            r_hdr_pend <= 1'b1;
`endif
          end
        end
        ST_SEND: begin
          r_trmt <= 1'b1;
`ifdef UART_SCHED_HDR_EN
          if (r_hdr_pend) begin
            r_tx_data  <= {4'hA, w_hdr_id};
            r_last_q   <= 1'b0;
            r_hdr_pend <= 1'b0;
          end else begin
`else
          begin
`endif
            r_tx_data  <= w_cur_byte;
            r_byte_ack <= r_gnt;
            r_last_q   <= bus.req_last[r_gidx];
          end
        end
        ST_WAIT: begin
          // Frame over (normal end or client withdrew mid-frame)
          if (w_wait_done && !w_frame_cont) r_gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.byte_ack = r_byte_ack;
  assign bus.trmt     = r_trmt;
  assign bus.tx_data  = r_tx_data;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for the UART frame scheduler with a small UART responder
// that holds tx_done low for a fixed number of cycles after each trmt.
module tb_uart_tx_sched;
  localparam int NR       = 4;
  localparam int UART_LEN = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   u_cnt = 0;

  uart_tx_sched_if #(.NUM_REQ(NR)) bus();

  uart_tx_sched #(.NUM_REQ(NR), .GAP_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // UART responder: done drops the cycle after trmt, returns UART_LEN later
  initial bus.tx_done = 1'b1;
  always @(posedge clk) begin
    if (bus.trmt) begin
      bus.tx_done <= 1'b0;
      u_cnt       <= UART_LEN;
    end else if (u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) bus.tx_done <= 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_trmt(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin step(); n++; end while (!bus.trmt && n < max_cyc);
    chk({tag, "_trmt"}, 32'(bus.trmt), 32'd1);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_byte(input int c, input logic [7:0] d, input logic last);
    bus.req_data[8*c +: 8] = d;
    bus.req_last[c]        = last;
  endtask

  initial begin
    int n;
    bus.req = '0; bus.req_last = '0; bus.req_data = '0;

    // 1. reset state and quiet idle
    do_reset();
    step();
    chk("rst_gnt",  32'(bus.gnt), 32'h0);
    chk("rst_trmt", 32'(bus.trmt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_txd",  32'(bus.tx_data), 32'h00);
    chk("rst_ack",  32'(bus.byte_ack), 32'h0);
    n = 0;
    repeat (50) begin step(); if (bus.trmt) n++; end
    chk("idle_no_trmt", 32'(n), 32'd0);

`ifdef UART_SCHED_HDR_EN
    // 6. header byte precedes the client byte, header gets no ack
    do_reset();
    set_byte(3, 8'h5A, 1'b1);
    bus.req = 4'b1000;
    wait_trmt("hdr0", 60);
    chk("hdr_txd", 32'(bus.tx_data), 32'hA3);
    chk("hdr_ack", 32'(bus.byte_ack), 32'h0);
    chk("hdr_gnt", 32'(bus.gnt), 32'h8);
    wait_trmt("hdr1", 60);
    chk("hdr_b_txd", 32'(bus.tx_data), 32'h5A);
    chk("hdr_b_ack", 32'(bus.byte_ack), 32'h8);
    bus.req = '0;
`else
    // 2. client 2 sends 11,22,33; latency 2 cycles; then 16-cycle gap
    set_byte(2, 8'h11, 1'b0);
    bus.req = 4'b0100;
    step();
    chk("t2_lat_gnt",  32'(bus.gnt), 32'h4);
    chk("t2_lat_trmt", 32'(bus.trmt), 32'h0);
    step();
    chk("t2_lat_trmt2", 32'(bus.trmt), 32'h1);
    chk("t2_b0_txd", 32'(bus.tx_data), 32'h11);
    chk("t2_b0_ack", 32'(bus.byte_ack), 32'h4);
    set_byte(2, 8'h22, 1'b0);
    wait_trmt("t2_b1", 60);
    chk("t2_b1_txd", 32'(bus.tx_data), 32'h22);
    chk("t2_b1_ack", 32'(bus.byte_ack), 32'h4);
    set_byte(2, 8'h33, 1'b1);
    wait_trmt("t2_b2", 60);
    chk("t2_b2_txd", 32'(bus.tx_data), 32'h33);
    chk("t2_b2_ack", 32'(bus.byte_ack), 32'h4);
    bus.req = '0;
    step();
    chk("t2_pulse_trmt", 32'(bus.trmt), 32'h0);
    chk("t2_pulse_ack",  32'(bus.byte_ack), 32'h0);
    chk("t2_txd_hold",   32'(bus.tx_data), 32'h33);
    n = 0;
    begin
      int c;
      c = 0;
      while (bus.gnt != '0 && c < 40) begin step(); c++; if (bus.trmt) n++; end
    end
    chk("t2_gnt_clr", 32'(bus.gnt), 32'h0);
    chk("t2_extra_trmt", 32'(n), 32'd0);
    chk("t2_gap_busy0", 32'(bus.busy), 32'h1);
    repeat (15) step();
    chk("t2_gap_busy15", 32'(bus.busy), 32'h1);
    step();
    chk("t2_gap_end", 32'(bus.busy), 32'h0);

    // 3. all four clients, 1-byte frames: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) set_byte(i, 8'hC0 + 8'(i), 1'b1);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_trmt($sformatf("t3_%0d", k), 80);
      chk($sformatf("t3_gnt%0d", k), 32'(bus.gnt), 32'(1 << (k % 4)));
      chk($sformatf("t3_txd%0d", k), 32'(bus.tx_data), 32'hC0 + 32'(k % 4));
      chk($sformatf("t3_ack%0d", k), 32'(bus.byte_ack), 32'(1 << (k % 4)));
    end
    bus.req = '0;

    // 3b. after client 1, clients 0 and 3 pending: 3 wins, then 0
    do_reset();
    set_byte(1, 8'hC1, 1'b1);
    set_byte(0, 8'hC0, 1'b1);
    set_byte(3, 8'hC3, 1'b1);
    bus.req = 4'b0010;
    wait_trmt("t3b_c1", 60);
    chk("t3b_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b1001;
    wait_trmt("t3b_c3", 80);
    chk("t3b_gnt3", 32'(bus.gnt), 32'h8);
    chk("t3b_txd3", 32'(bus.tx_data), 32'hC3);
    bus.req = 4'b0001;
    wait_trmt("t3b_c0", 80);
    chk("t3b_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = '0;

    // 4. client 1 withdraws during byte 2 of 4; client 2 granted next
    do_reset();
    set_byte(1, 8'h41, 1'b0);
    set_byte(2, 8'h52, 1'b1);
    bus.req = 4'b0110;
    wait_trmt("t4_b0", 60);
    chk("t4_gnt", 32'(bus.gnt), 32'h2);
    chk("t4_b0_txd", 32'(bus.tx_data), 32'h41);
    set_byte(1, 8'h42, 1'b0);
    wait_trmt("t4_b1", 60);
    chk("t4_b1_txd", 32'(bus.tx_data), 32'h42);
    set_byte(1, 8'h43, 1'b0);
    bus.req = 4'b0100;
    n = 0;
    begin
      int c;
      c = 0;
      while (bus.gnt != '0 && c < 40) begin step(); c++; if (bus.trmt) n++; end
    end
    chk("t4_abort_gnt",  32'(bus.gnt), 32'h0);
    chk("t4_no_trmt",    32'(n), 32'd0);
    chk("t4_abort_busy", 32'(bus.busy), 32'h1);
    wait_trmt("t4_next", 60);
    chk("t4_next_gnt", 32'(bus.gnt), 32'h4);
    chk("t4_next_txd", 32'(bus.tx_data), 32'h52);
    bus.req = '0;

    // 5. async reset mid-WAIT, then re-grant starting from client 0
    do_reset();
    set_byte(0, 8'hA0, 1'b0);
    set_byte(3, 8'hD3, 1'b1);
    bus.req = 4'b1001;
    wait_trmt("t5_pre", 60);
    chk("t5_pre_gnt", 32'(bus.gnt), 32'h1);
    chk("t5_pre_ack", 32'(bus.byte_ack), 32'h1);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt",  32'(bus.gnt), 32'h0);
    chk("t5_async_busy", 32'(bus.busy), 32'h0);
    chk("t5_async_trmt", 32'(bus.trmt), 32'h0);
    chk("t5_async_txd",  32'(bus.tx_data), 32'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("t5_regnt",      32'(bus.gnt), 32'h1);
    chk("t5_regnt_trmt", 32'(bus.trmt), 32'h0);
    step();
    chk("t5_re_trmt", 32'(bus.trmt), 32'h1);
    chk("t5_re_txd",  32'(bus.tx_data), 32'hA0);
    bus.req = '0;
`endif

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
